// File: rtl/hazard_scheduler.sv
// Interlock and forwarding scheduler for the 5-stage core: shadows EX/MEM/WB
// destinations, selects ID operand sources, and raises stall / gated fetch kill.
module hazard_scheduler #(
    parameter int REG_AW      = 3,
    parameter bit ZERO_REG    = 1'b1,
    parameter bit CTRL_EX_FWD = 1'b0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwr,
    input  logic              id_memrd,
    input  logic              id_ctrl,
    input  logic              kill_req,
    input  logic              cnt_clr,
    output logic              stall,
    output logic [1:0]        fwd1,
    output logic [1:0]        fwd2,
    output logic              killF,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_KILL  = 2'd2
    } state_e;

    state_e            state_q;
    logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic              ex_regwr_q, mem_regwr_q, wb_regwr_q;
    logic              ex_memrd_q, mem_memrd_q;
    logic [REG_AW-1:0] ex_rd_d;
    logic              ex_regwr_d, ex_memrd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic ex_hit, mem_hit;
    logic ld_use, ctrl_ex, ctrl_mem;

    function automatic logic stage_hit(input logic              regwr,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs,
                                       input logic              use_b,
                                       input logic              valid);
        logic zero_blk;
        zero_blk  = ZERO_REG && (rs == '0);
        stage_hit = regwr && (rd == rs) && use_b && valid && !zero_blk;
    endfunction

    // Newest producer wins so the most recent write to a register is forwarded.
    function automatic logic [1:0] fwd_sel(input logic hit_ex,
                                           input logic hit_mem,
                                           input logic hit_wb);
        if (hit_ex)       fwd_sel = 2'b01;
        else if (hit_mem) fwd_sel = 2'b10;
        else if (hit_wb)  fwd_sel = 2'b11;
        else              fwd_sel = 2'b00;
    endfunction

    always_comb begin
        ex_hit1  = stage_hit(ex_regwr_q,  ex_rd_q,  id_rs1, id_use1, id_valid);
        ex_hit2  = stage_hit(ex_regwr_q,  ex_rd_q,  id_rs2, id_use2, id_valid);
        mem_hit1 = stage_hit(mem_regwr_q, mem_rd_q, id_rs1, id_use1, id_valid);
        mem_hit2 = stage_hit(mem_regwr_q, mem_rd_q, id_rs2, id_use2, id_valid);
        wb_hit1  = stage_hit(wb_regwr_q,  wb_rd_q,  id_rs1, id_use1, id_valid);
        wb_hit2  = stage_hit(wb_regwr_q,  wb_rd_q,  id_rs2, id_use2, id_valid);
        ex_hit   = ex_hit1 | ex_hit2;
        mem_hit  = mem_hit1 | mem_hit2;

        ld_use   = ex_hit & ex_memrd_q;
        ctrl_ex  = id_ctrl & ex_hit & !CTRL_EX_FWD;
        ctrl_mem = id_ctrl & mem_hit & mem_memrd_q;
        stall    = ld_use | ctrl_ex | ctrl_mem;

        fwd1     = fwd_sel(ex_hit1, mem_hit1, wb_hit1);
        fwd2     = fwd_sel(ex_hit2, mem_hit2, wb_hit2);

        // A pending kill waits out any stall: the branch target is not resolved yet.
        killF    = kill_req & !stall & (state_q != ST_KILL);
    end

    always_comb begin
        ex_rd_d    = '0;
        ex_regwr_d = 1'b0;
        ex_memrd_d = 1'b0;
        if (id_valid && !stall) begin
            ex_rd_d    = id_rd;
            ex_regwr_d = id_regwr;
            ex_memrd_d = id_memrd;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rd_q     <= '0;
            ex_regwr_q  <= 1'b0;
            ex_memrd_q  <= 1'b0;
            mem_rd_q    <= '0;
            mem_regwr_q <= 1'b0;
            mem_memrd_q <= 1'b0;
            wb_rd_q     <= '0;
            wb_regwr_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ex_rd_q     <= ex_rd_d;
            ex_regwr_q  <= ex_regwr_d;
            ex_memrd_q  <= ex_memrd_d;
            mem_rd_q    <= ex_rd_q;
            mem_regwr_q <= ex_regwr_q;
            mem_memrd_q <= ex_memrd_q;
            wb_rd_q     <= mem_rd_q;
            wb_regwr_q  <= mem_regwr_q;
            cnt_q       <= cnt_d;
        end
    end

    // KILL is held for one cycle only; leaving it never re-enters KILL directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_STALL: begin
                    if (stall)         state_q <= ST_STALL;
                    else if (kill_req) state_q <= ST_KILL;
                    else               state_q <= ST_RUN;
                end
                ST_KILL: begin
                    if (stall) state_q <= ST_STALL;
                    else       state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign ex_rd        = ex_rd_q;
    assign mem_rd       = mem_rd_q;
    assign wb_rd        = wb_rd_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: vector table for forwarding/stall/kill,
// then hand sequences for counter saturation, clear priority and mid-stall reset.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use1, id_use2, id_regwr, id_memrd, id_ctrl;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        kill_req, cnt_clr;
    logic        stall, killF;
    logic [1:0]  fwd1, fwd2;
    logic [2:0]  ex_rd, mem_rd, wb_rd;
    logic [15:0] stall_cycles;

    logic        s_stall, s_killF;
    logic [1:0]  s_fwd1, s_fwd2;
    logic [2:0]  s_ex_rd, s_mem_rd, s_wb_rd;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.REG_AW(3), .ZERO_REG(1'b1), .CTRL_EX_FWD(1'b0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_memrd(id_memrd), .id_ctrl(id_ctrl), .kill_req(kill_req), .cnt_clr(cnt_clr),
        .stall(stall), .fwd1(fwd1), .fwd2(fwd2), .killF(killF), .ex_rd(ex_rd),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .stall_cycles(stall_cycles)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    hazard_scheduler #(.REG_AW(3), .ZERO_REG(1'b1), .CTRL_EX_FWD(1'b0), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_memrd(id_memrd), .id_ctrl(id_ctrl), .kill_req(kill_req), .cnt_clr(cnt_clr),
        .stall(s_stall), .fwd1(s_fwd1), .fwd2(s_fwd2), .killF(s_killF), .ex_rd(s_ex_rd),
        .mem_rd(s_mem_rd), .wb_rd(s_wb_rd), .stall_cycles(s_cnt)
    );

    typedef struct {
        logic        v;
        logic [2:0]  rs1, rs2;
        logic        u1, u2;
        logic [2:0]  rd;
        logic        wr, mr, ct, kr;
        logic        e_stall;
        logic [1:0]  e_f1, e_f2;
        logic        e_kf;
        logic [2:0]  e_exrd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic u1, input logic u2, input logic [2:0] rd,
                                input logic wr, input logic mr, input logic ct, input logic kr,
                                input logic st, input logic [1:0] f1, input logic [1:0] f2,
                                input logic kf, input logic [2:0] exrd, input logic [15:0] cnt);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
        t.wr = wr; t.mr = mr; t.ct = ct; t.kr = kr;
        t.e_stall = st; t.e_f1 = f1; t.e_f2 = f2; t.e_kf = kf; t.e_exrd = exrd; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v;  id_rs1 = t.rs1; id_rs2 = t.rs2; id_use1 = t.u1; id_use2 = t.u2;
        id_rd = t.rd;    id_regwr = t.wr; id_memrd = t.mr; id_ctrl = t.ct; kill_req = t.kr;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        //              v rs1 rs2 u1 u2 rd wr mr ct kr | st f1 f2 kf exrd cnt
        tbl[0]  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0); // ADD R3
        tbl[1]  = mk(1, 3, 5, 1, 1, 6, 1, 0, 0, 0,  0, 1, 0, 0, 3, 0); // R3 from EX
        tbl[2]  = mk(1, 3, 6, 1, 1, 7, 1, 0, 0, 0,  0, 2, 1, 0, 6, 0); // R3 from MEM
        tbl[3]  = mk(1, 3, 7, 1, 1, 0, 0, 0, 0, 0,  0, 3, 1, 0, 7, 0); // R3 from WB
        tbl[4]  = mk(1, 6, 0, 1, 0, 2, 1, 1, 0, 0,  0, 3, 0, 0, 0, 0); // LW R2
        tbl[5]  = mk(1, 7, 2, 1, 1, 5, 1, 0, 0, 0,  1, 3, 1, 0, 2, 0); // load-use stall
        tbl[6]  = mk(1, 7, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 2, 0, 0, 1); // bubble, fwd MEM
        tbl[7]  = mk(1, 5, 2, 1, 1, 0, 1, 0, 0, 0,  0, 1, 3, 0, 5, 1); // ADD R0
        tbl[8]  = mk(1, 0, 5, 1, 1, 4, 1, 1, 0, 0,  0, 0, 2, 0, 0, 1); // R0 no fwd; LW R4
        tbl[9]  = mk(1, 4, 5, 1, 1, 0, 0, 0, 1, 1,  1, 1, 3, 0, 4, 1); // BEQ R4, kill held
        tbl[10] = mk(1, 4, 5, 1, 1, 0, 0, 0, 1, 1,  1, 2, 0, 0, 0, 2); // load-to-branch
        tbl[11] = mk(1, 4, 5, 1, 1, 0, 0, 0, 1, 1,  0, 3, 0, 1, 0, 3); // kill released
        tbl[12] = mk(0, 4, 0, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3); // held kill masked
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 3); // plain kill
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3);
        tbl[16] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3); // ADD R1
        tbl[17] = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0, 0, 1, 3); // BNE on EX ALU
        tbl[18] = mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0,  0, 2, 0, 0, 0, 4);
        tbl[19] = mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 4); // use1 gates rs1

        reset = 1'b0;
        cnt_clr = 1'b0;
        idle();
        #2;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd1", 32'(fwd1), 0);
        chk("rst_fwd2", 32'(fwd2), 0);
        chk("rst_killF", 32'(killF), 0);
        chk("rst_rds", 32'({ex_rd, mem_rd, wb_rd}), 0);
        chk("rst_cnt", 32'(stall_cycles), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_fwd1", i), 32'(fwd1), 32'(tbl[i].e_f1));
            chk($sformatf("v%0d_fwd2", i), 32'(fwd2), 32'(tbl[i].e_f2));
            chk($sformatf("v%0d_killF", i), 32'(killF), 32'(tbl[i].e_kf));
            chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(tbl[i].e_exrd));
            chk($sformatf("v%0d_cnt", i), 32'(stall_cycles), 32'(tbl[i].e_cnt));
        end

        @(posedge clk);
        #1 idle();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("clr_cnt16", 32'(stall_cycles), 0);
        chk("clr_cnt4", 32'(s_cnt), 0);

        // Load-and-branch writing R4 and reading R4: two stall cycles out of every three.
        drive(mk(1, 4, 0, 1, 0, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 30; k++) begin
            #1 chk($sformatf("pat%0d_stall", k), 32'(stall), 32'((k % 3) != 1));
            @(posedge clk);
            #1;
        end
        chk("sat_cnt16", 32'(stall_cycles), 20);
        chk("sat_cnt4", 32'(s_cnt), 15);

        chk("c31_stall", 32'(stall), 0);
        @(posedge clk);
        #1 cnt_clr = 1'b1;
        chk("c32_stall", 32'(stall), 1);
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("clrprio_cnt16", 32'(stall_cycles), 0);
        chk("clrprio_cnt4", 32'(s_cnt), 0);
        chk("c33_stall", 32'(stall), 1);
        @(posedge clk);
        #1 chk("c33_cnt16", 32'(stall_cycles), 1);
        chk("c34_stall", 32'(stall), 0);
        @(posedge clk);
        #1;
        chk("c35_stall", 32'(stall), 1);
        chk("c35_ex_rd", 32'(ex_rd), 4);
        chk("c35_fwd1", 32'(fwd1), 1);

        reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_rds", 32'({ex_rd, mem_rd, wb_rd}), 0);
        chk("mid_rst_cnt", 32'(stall_cycles), 0);
        chk("mid_rst_fwd1", 32'(fwd1), 0);
        chk("mid_rst_killF", 32'(killF), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle();
        @(posedge clk);
        #1 chk("post_rst_cnt", 32'(stall_cycles), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
